// File: rtl/game_vga_mixer.sv
// VGA timing generator with priority sprite mixer and per-frame collision flag.
// A clock divider produces one pixel tick every CLK_DIV clk cycles; all video
// state advances on ticks, while frame_start is a single-clk pulse.
module game_vga_mixer #(
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned X_WIDTH   = 10,
   parameter int unsigned Y_WIDTH   = 10,
   parameter int unsigned RGB_WIDTH = 3,
   parameter int unsigned N_SPRITES = 2,
   parameter int unsigned CLK_DIV   = 2,
   parameter logic [RGB_WIDTH-1:0] BG_RGB = 3'b001
) (
   input  logic                           clk,
   input  logic                           reset,
   output logic [X_WIDTH-1:0]             pixel_x,
   output logic [Y_WIDTH-1:0]             pixel_y,
   output logic                           display_on,
   input  logic [N_SPRITES-1:0]           sprite_rgb_en,
   input  logic [N_SPRITES*RGB_WIDTH-1:0] sprite_rgb,
   output logic                           vga_hsync,
   output logic                           vga_vsync,
   output logic [RGB_WIDTH-1:0]           vga_rgb,
   output logic                           frame_start,
   output logic                           collision
);

   localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
   localparam int unsigned HS_END   = H_DISPLAY + H_FRONT + H_SYNC;
   localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
   localparam int unsigned VS_END   = V_DISPLAY + V_FRONT + V_SYNC;
   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0]     div_q, div_d;
   logic [X_WIDTH-1:0]   pixel_x_q, pixel_x_d;
   logic [Y_WIDTH-1:0]   pixel_y_q, pixel_y_d;
   logic                 display_on_q, display_on_d;
   logic                 hsync_q, hsync_d;
   logic                 vsync_q, vsync_d;
   logic [RGB_WIDTH-1:0] rgb_q, rgb_d;
   logic                 frame_start_q, frame_start_d;
   logic                 collision_q, collision_d;
   logic                 acc_q, acc_d;

   logic                 tick_c;
   logic                 x_end_c;
   logic                 y_end_c;
   logic                 wrap_c;
   logic                 any_en_c;
   logic                 overlap_c;
   logic                 seen_one_c;
   logic [RGB_WIDTH-1:0] sel_rgb_c;

   // Next-state logic: divider, raster counters, mixer, sync, collision
   always_comb begin
      div_d         = div_q;
      pixel_x_d     = pixel_x_q;
      pixel_y_d     = pixel_y_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      rgb_d         = rgb_q;
      frame_start_d = 1'b0;
      collision_d   = collision_q;
      acc_d         = acc_q;
      any_en_c      = 1'b0;
      overlap_c     = 1'b0;
      seen_one_c    = 1'b0;
      sel_rgb_c     = '0;

      tick_c  = (div_q == DIV_W'(CLK_DIV - 1));
      x_end_c = (pixel_x_q == X_WIDTH'(H_TOTAL - 1));
      y_end_c = (pixel_y_q == Y_WIDTH'(V_TOTAL - 1));
      wrap_c  = x_end_c && y_end_c;

      // Walk from the top index down so the lowest-index opaque sprite wins
      for (int i = N_SPRITES - 1; i >= 0; i--) begin
         if (sprite_rgb_en[i]) begin
            any_en_c  = 1'b1;
            sel_rgb_c = sprite_rgb[i*RGB_WIDTH +: RGB_WIDTH];
         end
      end

      // Two or more opaque sprites on the same pixel
      for (int i = 0; i < N_SPRITES; i++) begin
         if (seen_one_c && sprite_rgb_en[i]) overlap_c = 1'b1;
         if (sprite_rgb_en[i]) seen_one_c = 1'b1;
      end

      if (tick_c) begin
         div_d = '0;
         if (x_end_c) begin
            pixel_x_d = '0;
            pixel_y_d = y_end_c ? '0 : pixel_y_q + Y_WIDTH'(1);
         end else begin
            pixel_x_d = pixel_x_q + X_WIDTH'(1);
         end

         if (display_on_q) rgb_d = any_en_c ? sel_rgb_c : BG_RGB;
         else              rgb_d = '0;

         hsync_d = !((pixel_x_q >= X_WIDTH'(HS_START)) && (pixel_x_q < X_WIDTH'(HS_END)));
         vsync_d = !((pixel_y_q >= Y_WIDTH'(VS_START)) && (pixel_y_q < Y_WIDTH'(VS_END)));

         if (wrap_c) begin
            frame_start_d = 1'b1;
            collision_d   = acc_q | (display_on_q & overlap_c);
            acc_d         = 1'b0;
         end else if (display_on_q && overlap_c) begin
            acc_d = 1'b1;
         end
      end else begin
         div_d = div_q + DIV_W'(1);
      end

      display_on_d = (pixel_x_d < X_WIDTH'(H_DISPLAY)) && (pixel_y_d < Y_WIDTH'(V_DISPLAY));
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q         <= '0;
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         display_on_q  <= 1'b1;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         rgb_q         <= '0;
         frame_start_q <= 1'b0;
         collision_q   <= 1'b0;
         acc_q         <= 1'b0;
      end else begin
         div_q         <= div_d;
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
         display_on_q  <= display_on_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
         collision_q   <= collision_d;
         acc_q         <= acc_d;
      end
   end

   assign pixel_x     = pixel_x_q;
   assign pixel_y     = pixel_y_q;
   assign display_on  = display_on_q;
   assign vga_hsync   = hsync_q;
   assign vga_vsync   = vsync_q;
   assign vga_rgb     = rgb_q;
   assign frame_start = frame_start_q;
   assign collision   = collision_q;

endmodule

// File: tb/tb_game_vga_mixer.sv
// Directed bench for game_vga_mixer using a shrunken raster:
// 15 px per line (8 visible, sync at 10..12), 8 lines (4 visible, sync at 5..6).
module tb_game_vga_mixer;

   localparam int unsigned HD = 8, HF = 2, HS = 3, HB = 2;
   localparam int unsigned VD = 4, VF = 1, VS = 2, VB = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   logic [9:0] pixel_x, pixel_y;
   logic       display_on, vga_hsync, vga_vsync, frame_start, collision;
   logic [1:0] sprite_rgb_en = '0;
   logic [5:0] sprite_rgb = '0;
   logic [2:0] vga_rgb;

   logic [9:0] pixel_x4, pixel_y4;
   logic       display_on4, vga_hsync4, vga_vsync4, frame_start4, collision4;
   logic [1:0] sprite_rgb_en4 = '0;
   logic [5:0] sprite_rgb4 = '0;
   logic [2:0] vga_rgb4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   game_vga_mixer #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .X_WIDTH(10), .Y_WIDTH(10), .RGB_WIDTH(3), .N_SPRITES(2),
      .CLK_DIV(2), .BG_RGB(3'b001)
   ) u_dut (
      .clk(clk), .reset(reset),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .display_on(display_on),
      .sprite_rgb_en(sprite_rgb_en), .sprite_rgb(sprite_rgb),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_rgb(vga_rgb),
      .frame_start(frame_start), .collision(collision)
   );

   game_vga_mixer #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .X_WIDTH(10), .Y_WIDTH(10), .RGB_WIDTH(3), .N_SPRITES(2),
      .CLK_DIV(4), .BG_RGB(3'b001)
   ) u_dut4 (
      .clk(clk), .reset(reset),
      .pixel_x(pixel_x4), .pixel_y(pixel_y4), .display_on(display_on4),
      .sprite_rgb_en(sprite_rgb_en4), .sprite_rgb(sprite_rgb4),
      .vga_hsync(vga_hsync4), .vga_vsync(vga_vsync4), .vga_rgb(vga_rgb4),
      .frame_start(frame_start4), .collision(collision4)
   );

   // Advance n rising edges, then settle 1 time unit past the last edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Run until the CLK_DIV=2 instance enters pixel (x,y); returns just after that tick edge
   task automatic goto(input int x, input int y);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         step(1);
         if (pixel_x == 10'(x) && pixel_y == 10'(y)) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL goto(%0d,%0d) timeout, at (%0d,%0d)", x, y, pixel_x, pixel_y);
      end
   endtask

   task automatic goto4(input int x, input int y);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 4000 && !found; i++) begin
         step(1);
         if (pixel_x4 == 10'(x) && pixel_y4 == 10'(y)) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL goto4(%0d,%0d) timeout, at (%0d,%0d)", x, y, pixel_x4, pixel_y4);
      end
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      step(n);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step(3);
      checks += 8;
      if (pixel_x !== 10'd0)    begin failures++; $display("FAIL rst_pixel_x got %0d exp 0", pixel_x); end
      if (pixel_y !== 10'd0)    begin failures++; $display("FAIL rst_pixel_y got %0d exp 0", pixel_y); end
      if (display_on !== 1'b1)  begin failures++; $display("FAIL rst_display_on got %b exp 1", display_on); end
      if (vga_hsync !== 1'b1)   begin failures++; $display("FAIL rst_hsync got %b exp 1", vga_hsync); end
      if (vga_vsync !== 1'b1)   begin failures++; $display("FAIL rst_vsync got %b exp 1", vga_vsync); end
      if (vga_rgb !== 3'd0)     begin failures++; $display("FAIL rst_rgb got %b exp 000", vga_rgb); end
      if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_frame_start got %b exp 0", frame_start); end
      if (collision !== 1'b0)   begin failures++; $display("FAIL rst_collision got %b exp 0", collision); end
      reset = 1'b0;
      step(1);
      checks++;
      if (pixel_x !== 10'd0) begin failures++; $display("FAIL rel_x_edge1 got %0d exp 0", pixel_x); end
      step(1);
      checks++;
      if (pixel_x !== 10'd1) begin failures++; $display("FAIL rel_x_edge2 got %0d exp 1", pixel_x); end
   endtask

   task automatic test_colour;
      goto(3, 1);
      sprite_rgb    = {3'b100, 3'b010};
      sprite_rgb_en = 2'b11;
      step(2);
      checks++;
      if (vga_rgb !== 3'b010) begin failures++; $display("FAIL rgb_both got %b exp 010", vga_rgb); end
      sprite_rgb_en = 2'b10;
      step(2);
      checks++;
      if (vga_rgb !== 3'b100) begin failures++; $display("FAIL rgb_s1 got %b exp 100", vga_rgb); end
      sprite_rgb_en = 2'b00;
      step(2);
      checks++;
      if (vga_rgb !== 3'b001) begin failures++; $display("FAIL rgb_bg got %b exp 001", vga_rgb); end
      goto(9, 1);
      sprite_rgb_en = 2'b11;
      step(2);
      checks++;
      if (vga_rgb !== 3'b000) begin failures++; $display("FAIL rgb_hblank got %b exp 000", vga_rgb); end
      sprite_rgb_en = 2'b00;
      goto(3, 5);
      sprite_rgb_en = 2'b01;
      step(2);
      checks++;
      if (vga_rgb !== 3'b000) begin failures++; $display("FAIL rgb_vblank got %b exp 000", vga_rgb); end
      sprite_rgb_en = 2'b00;
   endtask

   task automatic test_sync;
      int lows, first;
      lows = 0; first = -1;
      goto(0, 2);
      for (int k = 0; k < 15; k++) begin
         step(2);
         if (!vga_hsync) begin
            lows++;
            if (first < 0) first = k;
         end
      end
      checks += 2;
      if (lows != 3)   begin failures++; $display("FAIL hsync_low_count got %0d exp 3", lows); end
      if (first != 10) begin failures++; $display("FAIL hsync_first_low got %0d exp 10", first); end
      lows = 0; first = -1;
      goto(0, 0);
      for (int k = 0; k < 120; k++) begin
         step(2);
         if (!vga_vsync) begin
            lows++;
            if (first < 0) first = k;
         end
      end
      checks += 2;
      if (lows != 30)  begin failures++; $display("FAIL vsync_low_count got %0d exp 30", lows); end
      if (first != 75) begin failures++; $display("FAIL vsync_first_low got %0d exp 75", first); end
   endtask

   task automatic test_frame_start;
      int n;
      bit seen;
      goto(14, 7);
      step(1);
      checks++;
      if (frame_start !== 1'b0) begin failures++; $display("FAIL fs_early got %b exp 0", frame_start); end
      step(1);
      checks += 3;
      if (frame_start !== 1'b1) begin failures++; $display("FAIL fs_pulse got %b exp 1", frame_start); end
      if (pixel_x !== 10'd0)    begin failures++; $display("FAIL fs_wrap_x got %0d exp 0", pixel_x); end
      if (pixel_y !== 10'd0)    begin failures++; $display("FAIL fs_wrap_y got %0d exp 0", pixel_y); end
      n = 0; seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         step(1);
         n++;
         if (frame_start) seen = 1'b1;
      end
      checks++;
      if (n != 240) begin failures++; $display("FAIL fs_period got %0d exp 240", n); end
      step(1);
      checks++;
      if (frame_start !== 1'b0) begin failures++; $display("FAIL fs_width got %b exp 0", frame_start); end
   endtask

   task automatic test_collision;
      apply_reset(2);
      goto(2, 1);
      sprite_rgb_en = 2'b11;
      step(2);
      sprite_rgb_en = 2'b00;
      checks++;
      if (collision !== 1'b0) begin failures++; $display("FAIL col_same_frame got %b exp 0", collision); end
      goto(14, 7);
      step(2);
      checks++;
      if (collision !== 1'b1) begin failures++; $display("FAIL col_set got %b exp 1", collision); end
      goto(7, 3);
      checks++;
      if (collision !== 1'b1) begin failures++; $display("FAIL col_hold got %b exp 1", collision); end
      goto(14, 7);
      step(1);
      checks++;
      if (collision !== 1'b1) begin failures++; $display("FAIL col_hold_end got %b exp 1", collision); end
      step(1);
      checks++;
      if (collision !== 1'b0) begin failures++; $display("FAIL col_clear got %b exp 0", collision); end
      goto(9, 1);
      sprite_rgb_en = 2'b11;
      step(2);
      sprite_rgb_en = 2'b00;
      goto(14, 7);
      step(2);
      checks++;
      if (collision !== 1'b0) begin failures++; $display("FAIL col_blank_ignored got %b exp 0", collision); end
   endtask

   task automatic test_reset_midframe;
      int fs_hits;
      goto(5, 2);
      reset = 1'b1;
      #1;
      checks += 4;
      if (pixel_x !== 10'd0)  begin failures++; $display("FAIL mid_x got %0d exp 0", pixel_x); end
      if (pixel_y !== 10'd0)  begin failures++; $display("FAIL mid_y got %0d exp 0", pixel_y); end
      if (vga_hsync !== 1'b1) begin failures++; $display("FAIL mid_hsync got %b exp 1", vga_hsync); end
      if (vga_rgb !== 3'd0)   begin failures++; $display("FAIL mid_rgb got %b exp 000", vga_rgb); end
      step(3);
      reset = 1'b0;
      step(1);
      checks++;
      if (pixel_x !== 10'd0) begin failures++; $display("FAIL mid_rel1 got %0d exp 0", pixel_x); end
      step(1);
      checks++;
      if (pixel_x !== 10'd1) begin failures++; $display("FAIL mid_rel2 got %0d exp 1", pixel_x); end
      fs_hits = 0;
      for (int i = 0; i < 200; i++) begin
         step(1);
         if (frame_start) fs_hits++;
      end
      checks++;
      if (fs_hits != 0) begin failures++; $display("FAIL mid_spurious_fs got %0d exp 0", fs_hits); end
   endtask

   task automatic test_clkdiv4;
      int n;
      goto4(3, 1);
      sprite_rgb4    = {3'b000, 3'b110};
      sprite_rgb_en4 = 2'b01;
      step(3);
      checks += 2;
      if (vga_rgb4 !== 3'b001) begin failures++; $display("FAIL div4_rgb_pre got %b exp 001", vga_rgb4); end
      if (pixel_x4 !== 10'd3)  begin failures++; $display("FAIL div4_x_hold got %0d exp 3", pixel_x4); end
      step(1);
      checks += 2;
      if (vga_rgb4 !== 3'b110) begin failures++; $display("FAIL div4_rgb got %b exp 110", vga_rgb4); end
      if (pixel_x4 !== 10'd4)  begin failures++; $display("FAIL div4_x_adv got %0d exp 4", pixel_x4); end
      sprite_rgb_en4 = 2'b00;
      n = 0;
      do begin
         step(1);
         n++;
      end while (pixel_x4 == 10'd4 && n < 20);
      checks++;
      if (n != 4) begin failures++; $display("FAIL div4_period got %0d exp 4", n); end
   endtask

   initial begin
      test_reset();
      test_colour();
      test_sync();
      test_frame_start();
      test_collision();
      test_reset_midframe();
      test_clkdiv4();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
